// File: rtl/r2rv_pkg.sv
// Shared register-file geometry and the small types used by the writeback path.
package r2rv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_W  = 5;
    localparam int NREGS  = 32;
    localparam int WAIT_W = 4;
    localparam int CNT_W  = 5;

    typedef logic [REG_W-1:0] regaddr_t;
    typedef logic [XLEN-1:0]  word_t;

    function automatic logic is_x0(input regaddr_t ra);
        return ra == '0;
    endfunction
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard and outstanding-op counter for long-latency ops.
module wb_scoreboard
    import r2rv_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     iss_valid,
    output logic     iss_ready,
    input  regaddr_t iss_rd,
    input  logic     b_hs,
    input  regaddr_t b_wa,
    input  regaddr_t ra1,
    input  regaddr_t ra2,
    output logic     hz1,
    output logic     hz2,
    output logic     hzw
);
    logic [NREGS-1:0] pending_reg;
    logic [CNT_W-1:0] out_cnt_reg;
    logic [CNT_W-1:0] out_cnt_next;
    logic             iss_hs;

    assign iss_ready = !reset && (out_cnt_reg < CNT_W'(MAX_OUT));
    assign iss_hs    = iss_valid && iss_ready;

    always_comb begin
        out_cnt_next = out_cnt_reg;
        if (iss_hs && !b_hs)
            out_cnt_next = out_cnt_reg + 1'b1;
        else if (!iss_hs && b_hs && out_cnt_reg != '0)
            out_cnt_next = out_cnt_reg - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_cnt_reg <= '0;
        else
            out_cnt_reg <= out_cnt_next;
    end

    // x0 can never be pending; set beats clear when both hit one register.
    assign pending_reg[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_pend
            logic set_bit;
            logic clr_bit;
            assign set_bit = iss_hs && (iss_rd == REG_W'(gi));
            assign clr_bit = b_hs && (b_wa == REG_W'(gi));
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    pending_reg[gi] <= 1'b0;
                else if (set_bit)
                    pending_reg[gi] <= 1'b1;
                else if (clr_bit)
                    pending_reg[gi] <= 1'b0;
            end
        end
    endgenerate

    assign hz1 = !reset && pending_reg[ra1];
    assign hz2 = !reset && pending_reg[ra2];
    assign hzw = !reset && pending_reg[iss_rd];

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(b_hs && out_cnt_reg == '0));
    a_no_waw_issue: assert property (@(posedge clk) disable iff (reset)
        !(iss_hs && hzw));
endmodule

// File: rtl/rf_wb_ctrl.sv
// Shares the register-file write port between pipeline writeback (A) and a
// long-latency unit (B), with bounded starvation of B, plus hazard scoreboard.
module rf_wb_ctrl
    import r2rv_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int MAX_OUT  = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     a_valid,
    output logic     a_ready,
    input  regaddr_t a_wa,
    input  word_t    a_wd,
    input  logic     b_valid,
    output logic     b_ready,
    input  regaddr_t b_wa,
    input  word_t    b_wd,
    input  logic     iss_valid,
    output logic     iss_ready,
    input  regaddr_t iss_rd,
    input  regaddr_t ra1,
    input  regaddr_t ra2,
    output logic     hz1,
    output logic     hz2,
    output logic     hzw,
    output logic     we3,
    output regaddr_t wa3,
    output word_t    wd3
);
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              force_b;
    logic              grant_a;
    logic              grant_b;
    logic              b_hs;

    // A normally wins; B is forced through once it has waited MAX_WAIT cycles.
    assign force_b = b_valid && (wait_cnt_reg == WAIT_W'(MAX_WAIT));
    assign grant_b = !reset && (force_b || (!a_valid && b_valid));
    assign grant_a = !reset && a_valid && !force_b;
    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign b_hs    = b_valid && b_ready;

    always_comb begin
        wa3 = '0;
        wd3 = '0;
        if (grant_b) begin
            wa3 = b_wa;
            wd3 = b_wd;
        end else if (grant_a) begin
            wa3 = a_wa;
            wd3 = a_wd;
        end
    end

    assign we3 = (grant_a || grant_b) && !is_x0(wa3);

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!b_valid || b_hs)
            wait_cnt_next = '0;
        else if (wait_cnt_reg < WAIT_W'(MAX_WAIT))
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt_reg <= '0;
        else
            wait_cnt_reg <= wait_cnt_next;
    end

    wb_scoreboard #(.MAX_OUT(MAX_OUT)) u_sb (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .b_hs      (b_hs),
        .b_wa      (b_wa),
        .ra1       (ra1),
        .ra2       (ra2),
        .hz1       (hz1),
        .hz2       (hz2),
        .hzw       (hzw)
    );
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: arbitration, starvation bound, scoreboard, reset.
module tb_rf_wb_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, iss_valid;
    logic        a_ready, b_ready, iss_ready;
    logic [4:0]  a_wa, b_wa, iss_rd, ra1, ra2, wa3;
    logic [31:0] a_wd, b_wd, wd3;
    logic        hz1, hz2, hzw, we3;

    int checks = 0;
    int errors = 0;

    rf_wb_ctrl #(.MAX_WAIT(4), .MAX_OUT(4)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .ra1(ra1), .ra2(ra2), .hz1(hz1), .hz2(hz2), .hzw(hzw),
        .we3(we3), .wa3(wa3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; iss_valid = 0;
        a_wa = 0; a_wd = 0; b_wa = 0; b_wd = 0; iss_rd = 0;
    endtask

    initial begin
        idle();
        ra1 = 0; ra2 = 0;
        reset = 1;
        a_valid = 1; a_wa = 5; a_wd = 32'h1111_1111;
        #2;
        chk("rst_a_ready", 32'(a_ready), 0);
        chk("rst_iss_ready", 32'(iss_ready), 0);
        chk("rst_we3", 32'(we3), 0);
        chk("rst_wa3", 32'(wa3), 0);
        chk("rst_wd3", 32'(wd3), 0);
        tick();
        idle();
        reset = 0;
        #1;
        chk("idle_iss_ready", 32'(iss_ready), 1);
        chk("idle_we3", 32'(we3), 0);

        // A-only writeback, then a write to x0
        a_valid = 1; a_wa = 5; a_wd = 32'hDEAD_BEEF; #1;
        chk("a_ready", 32'(a_ready), 1);
        chk("a_we3", 32'(we3), 1);
        chk("a_wa3", 32'(wa3), 5);
        chk("a_wd3", wd3, 32'hDEAD_BEEF);
        tick();
        a_wa = 0; #1;
        chk("a_x0_ready", 32'(a_ready), 1);
        chk("a_x0_we3", 32'(we3), 0);
        tick();
        idle(); #1;
        chk("nogrant_wd3", wd3, 0);

        // Issue to x7, hazard visible next cycle, B write clears it a cycle later
        iss_valid = 1; iss_rd = 7; ra1 = 7; ra2 = 7; #1;
        chk("iss7_ready", 32'(iss_ready), 1);
        chk("iss7_hz1_same", 32'(hz1), 0);
        tick();
        iss_valid = 0; #1;
        chk("iss7_hz1", 32'(hz1), 1);
        chk("iss7_hz2", 32'(hz2), 1);
        ra1 = 8; #1;
        chk("ra8_hz1", 32'(hz1), 0);
        ra1 = 7;
        b_valid = 1; b_wa = 7; b_wd = 32'h0000_1234; #1;
        chk("b7_ready", 32'(b_ready), 1);
        chk("b7_we3", 32'(we3), 1);
        chk("b7_wa3", 32'(wa3), 7);
        chk("b7_wd3", wd3, 32'h0000_1234);
        chk("b7_hz1_nobypass", 32'(hz1), 1);
        tick();
        idle(); #1;
        chk("b7_hz1_cleared", 32'(hz1), 0);

        // Four issues to x0 fill the outstanding budget
        for (int i = 0; i < 4; i++) begin
            iss_valid = 1; iss_rd = 0; #1;
            chk($sformatf("fill%0d_ready", i), 32'(iss_ready), 1);
            chk($sformatf("fill%0d_hzw", i), 32'(hzw), 0);
            tick();
        end
        iss_valid = 0; #1;
        chk("full_iss_ready", 32'(iss_ready), 0);
        b_valid = 1; b_wa = 0; #1;
        chk("bx0_ready", 32'(b_ready), 1);
        chk("bx0_we3", 32'(we3), 0);
        tick();
        b_valid = 0; #1;
        chk("cnt3_iss_ready", 32'(iss_ready), 1);
        iss_valid = 1; iss_rd = 0; b_valid = 1; b_wa = 0;
        tick();
        idle(); #1;
        chk("simul_cnt3_ready", 32'(iss_ready), 1);
        iss_valid = 1; iss_rd = 0;
        tick();
        iss_valid = 0; #1;
        chk("refull_iss_ready", 32'(iss_ready), 0);

        // Starvation: B refused four cycles, forced on the fifth
        a_valid = 1; a_wa = 5; a_wd = 32'h0000_AAAA;
        b_valid = 1; b_wa = 3; b_wd = 32'h0000_B0B0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("starve%0d_a_ready", i), 32'(a_ready), 1);
            chk($sformatf("starve%0d_b_ready", i), 32'(b_ready), 0);
            tick();
        end
        #1;
        chk("force_b_ready", 32'(b_ready), 1);
        chk("force_a_ready", 32'(a_ready), 0);
        chk("force_wa3", 32'(wa3), 3);
        chk("force_wd3", wd3, 32'h0000_B0B0);
        tick();
        #1;
        chk("after_a_ready", 32'(a_ready), 1);
        chk("after_b_ready", 32'(b_ready), 0);
        tick();
        idle();  // outstanding count now 3

        // Same-cycle set and clear of x9: set wins
        iss_valid = 1; iss_rd = 9; b_valid = 1; b_wa = 9; #1;
        chk("x9_b_ready", 32'(b_ready), 1);
        chk("x9_iss_ready", 32'(iss_ready), 1);
        tick();
        idle(); ra1 = 9; #1;
        chk("x9_pending", 32'(hz1), 1);

        // Build three pending registers, then reset mid-cycle
        iss_valid = 1; iss_rd = 10; b_valid = 1; b_wa = 2;
        tick();
        iss_valid = 1; iss_rd = 11; b_valid = 1; b_wa = 0;
        tick();
        idle();
        ra1 = 9; ra2 = 10; iss_rd = 11; #1;
        chk("pre_rst_hz1", 32'(hz1), 1);
        chk("pre_rst_hz2", 32'(hz2), 1);
        chk("pre_rst_hzw", 32'(hzw), 1);
        a_valid = 1; a_wa = 4; b_valid = 1; b_wa = 6;
        #1;
        reset = 1;
        #1;
        chk("arst_hz1", 32'(hz1), 0);
        chk("arst_hz2", 32'(hz2), 0);
        chk("arst_hzw", 32'(hzw), 0);
        chk("arst_a_ready", 32'(a_ready), 0);
        chk("arst_b_ready", 32'(b_ready), 0);
        chk("arst_iss_ready", 32'(iss_ready), 0);
        chk("arst_we3", 32'(we3), 0);
        a_valid = 0; b_valid = 0;
        tick();
        reset = 0; #1;
        chk("post_rst_hz1", 32'(hz1), 0);
        chk("post_rst_hz2", 32'(hz2), 0);
        chk("post_rst_hzw", 32'(hzw), 0);
        for (int i = 0; i < 4; i++) begin
            iss_valid = 1; iss_rd = 0; #1;
            chk($sformatf("post_rst_fill%0d", i), 32'(iss_ready), 1);
            tick();
        end
        iss_valid = 0; #1;
        chk("post_rst_full", 32'(iss_ready), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
